// File: rtl/aes_128_round_ctrl.sv
// Purpose: round sequencer for an iterative AES-128 datapath (load, ROUNDS rounds, hold result).
// Latency: block accepted at edge T runs rounds at edges T+1..T+ROUNDS; out_valid from T+ROUNDS.
// Backpressure: out_ready low holds the result in DONE; in_ready low during ROUND and stalled DONE.
module aes_128_round_ctrl #(
    parameter int ROUNDS = 10,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dp_load,
    output logic             dp_round_en,
    output logic             dp_skip_mix,
    output logic [3:0]       round,
    output logic [7:0]       rcon,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             accept;
    logic             handoff;

    // GF(2^8) doubling used to step the key-expansion round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Handshake decode; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
        accept   = in_valid & in_ready;
        handoff  = (state_q == DONE) & out_ready;
    end

    // Next-state, round index and round constant sequencing.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ROUND;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                end
            end
            ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                    round_d = 4'd0;
                    rcon_d  = 8'h00;
                end else begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                end
            end
            DONE: begin
                if (handoff) begin
                    if (accept) begin
                        // Back-to-back: the next block loads in the handoff cycle.
                        state_d = ROUND;
                        round_d = 4'd1;
                        rcon_d  = 8'h01;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                rcon_d  = 8'h00;
            end
        endcase
    end

    // State registers; reset wins over any accept or handoff in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Completed-block counter, wraps freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (handoff) begin
            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        end
    end

    // Datapath strobes and status outputs.
    always_comb begin
        dp_load     = accept;
        dp_round_en = (state_q == ROUND);
        dp_skip_mix = (state_q == ROUND) & (round_q == LAST_ROUND);
        out_valid   = (state_q == DONE);
        busy        = (state_q == ROUND) | (state_q == DONE);
        round       = round_q;
        rcon        = rcon_q;
        blk_cnt     = blk_cnt_q;
    end

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// Purpose: directed self-checking bench for aes_128_round_ctrl (16-bit and 2-bit counter instances).
// Latency: checks sampled on the falling edge, half a cycle after each state update.
// Backpressure: exercises output stalls, back-to-back traffic and in-round input holding.
module tb_aes_128_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready, out_valid, dp_load, dp_round_en, dp_skip_mix, busy;
    logic [3:0] round;
    logic [7:0] rcon;
    logic [15:0] blk_cnt;

    logic       in_ready_b, out_valid_b, dp_load_b, dp_round_en_b, dp_skip_mix_b, busy_b;
    logic [3:0] round_b;
    logic [7:0] rcon_b;
    logic [1:0] blk_cnt_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;
    int last_ov;

    logic [7:0] rc_tab [1:10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_128_round_ctrl #(.ROUNDS(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .dp_load(dp_load),
        .dp_round_en(dp_round_en), .dp_skip_mix(dp_skip_mix), .round(round),
        .rcon(rcon), .busy(busy), .blk_cnt(blk_cnt)
    );

    aes_128_round_ctrl #(.ROUNDS(10), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .dp_load(dp_load_b),
        .dp_round_en(dp_round_en_b), .dp_skip_mix(dp_skip_mix_b), .round(round_b),
        .rcon(rcon_b), .busy(busy_b), .blk_cnt(blk_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rc_tab[1] = 8'h01; rc_tab[2] = 8'h02; rc_tab[3] = 8'h04; rc_tab[4]  = 8'h08;
        rc_tab[5] = 8'h10; rc_tab[6] = 8'h20; rc_tab[7] = 8'h40; rc_tab[8]  = 8'h80;
        rc_tab[9] = 8'h1B; rc_tab[10] = 8'h36;

        // Reset with in_valid asserted: no load, no ready, everything cleared.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dp_load", dp_load, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round", round, 0);
        chk("rst_rcon", rcon, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_b_state", {dp_load_b, in_ready_b, dp_round_en_b, busy_b, round_b, rcon_b}, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_dp_load", dp_load, 0);

        // Single block.
        in_valid = 1'b1;
        #1 chk("single_dp_load", dp_load, 1);
        step();
        in_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            chk($sformatf("single_round_en_%0d", r), dp_round_en, 1);
            chk($sformatf("single_round_%0d", r), round, r);
            chk($sformatf("single_rcon_%0d", r), rcon, rc_tab[r]);
            chk($sformatf("single_skip_%0d", r), dp_skip_mix, (r == 10));
            chk($sformatf("single_ov_%0d", r), {out_valid, in_ready, dp_load}, 0);
            step();
        end
        chk("single_done_ov", out_valid, 1);
        chk("single_done_round", {round, rcon}, 0);
        chk("single_done_ren", dp_round_en, 0);
        step();
        chk("single_after_ov", out_valid, 0);
        chk("single_after_busy", busy, 0);
        chk("single_blk_cnt", blk_cnt, 1);

        // In-round input held high, then output stall for 5 cycles.
        out_ready = 1'b0; in_valid = 1'b1;
        #1 chk("stall_accept", dp_load, 1);
        step();
        for (int r = 1; r <= 10; r++) begin
            chk($sformatf("hold_no_load_%0d", r), {dp_load, in_ready}, 0);
            chk($sformatf("hold_round_%0d", r), round, r);
            step();
        end
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall_ov_%0d", s), out_valid, 1);
            chk($sformatf("stall_quiet_%0d", s), {in_ready, dp_load, dp_round_en}, 0);
            chk($sformatf("stall_cnt_%0d", s), blk_cnt, 1);
            step();
        end
        out_ready = 1'b1;
        #1 chk("stall_release_rdy", in_ready, 1);
        step();
        chk("stall_release_cnt", blk_cnt, 2);
        chk("stall_release_idle", {out_valid, busy}, 0);

        // Back-to-back: five blocks, checks the 2-bit counter wrap as well.
        do_reset();
        chk("b2b_cnt_clear", blk_cnt, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("b2b_first_load", dp_load, 1);
        step();
        last_ov = 0;
        for (int b = 1; b <= 5; b++) begin
            for (int r = 1; r <= 10; r++) begin
                chk($sformatf("b2b%0d_round_%0d", b, r), {busy, dp_round_en, round}, {2'b11, 4'(r)});
                chk($sformatf("b2b%0d_rcon_%0d", b, r), rcon, rc_tab[r]);
                step();
            end
            chk($sformatf("b2b%0d_ov", b), {out_valid, out_valid_b, busy}, 3'b111);
            if (b > 1) chk($sformatf("b2b%0d_period", b), cyc - last_ov, 11);
            last_ov = cyc;
            if (b == 5) in_valid = 1'b0;
            #1 chk($sformatf("b2b%0d_load", b), dp_load, (b < 5));
            chk($sformatf("b2b%0d_cnt_pre", b), blk_cnt, b - 1);
            step();
            chk($sformatf("b2b%0d_cnt", b), blk_cnt, b);
            chk($sformatf("b2b%0d_cnt_w2", b), blk_cnt_b, b % 4);
        end
        chk("b2b_end_idle", {busy, out_valid, in_ready}, 3'b001);

        // Reset mid-ROUND at round 5 with in_valid high.
        in_valid = 1'b1;
        step();
        for (int r = 1; r < 5; r++) step();
        chk("midrst_round5", round, 5);
        rst_n = 1'b0;
        #1 chk("midrst_comb", {in_ready, dp_load}, 0);
        step();
        chk("midrst_round", round, 0);
        chk("midrst_rcon", rcon, 0);
        chk("midrst_ov", {out_valid, busy}, 0);
        chk("midrst_cnt", blk_cnt, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1 chk("midrst_rdy", in_ready, 1);

        // Reset in DONE with out_ready and in_valid high: no handoff, no accept.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 1; r <= 10; r++) step();
        chk("donerst_pre_ov", out_valid, 1);
        in_valid = 1'b1; rst_n = 1'b0;
        step();
        chk("donerst_state", {out_valid, busy, dp_round_en, round}, 0);
        chk("donerst_cnt", blk_cnt, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("donerst_idle", {out_valid, busy}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
